pc_sequencer: RTL and testbench

Control-side driver for the program-counter block. It generates the 2-bit PC opcode and the jump target, and reads back the current PC and the link value the PC captures on a jump. It sits between the core control path (start/stall/jump/halt requests) and the PC register. It handles stall holding, one-deep pending jumps, alignment checking, link capture and an increment counter.

---
 rtl/pc_pkg.sv | 25 ++
 rtl/sat_counter.sv | 29 ++
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 tb/tb_pc_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Brief    : Opcode/state types shared by the PC sequencer and the PC block.
// Revision : 1.0
// ============================================================================
package pc_pkg;

   typedef enum logic [1:0] {
      PC_CLR  = 2'b00,
      PC_HOLD = 2'b01,
      PC_INC  = 2'b10,
      PC_JUMP = 2'b11
   } pc_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } seq_state_t;

   localparam int unsigned c_DEFAULT_STEP = 4;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones; synchronous clear wins.
// Revision : 1.0
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Drives PC opcodes/targets, holds one pending jump, captures link.
// Revision : 1.0
// ============================================================================
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int ANCHO = 4,
   parameter int CNT_W = 8,
   parameter int STEP  = c_DEFAULT_STEP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             jump_req_i,
   input  logic [ANCHO-1:0] jump_addr_i,
   input  logic             halt_i,
   input  logic [ANCHO-1:0] pc_value_i,
   input  logic [ANCHO-1:0] link_i,
   output logic [1:0]       pc_op_o,
   output logic [ANCHO-1:0] pc_target_o,
   output logic             running_o,
   output logic             halted_o,
   output logic             err_align_o,
   output logic             wrap_o,
   output logic [ANCHO-1:0] link_o,
   output logic             link_valid_o,
   output logic [CNT_W-1:0] inc_count_o
);

   localparam logic [ANCHO-1:0] c_ALIGN_MASK = ANCHO'(STEP - 1);
   localparam logic [ANCHO-1:0] c_WRAP_PC    = ANCHO'((2 ** ANCHO) - STEP);

   seq_state_t       r_state,     w_state_nxt;
   pc_op_t           r_op,        w_op_nxt;
   logic [ANCHO-1:0] r_target,    w_target_nxt;
   logic [ANCHO-1:0] r_pend_addr, w_pend_addr_nxt;
   logic             r_pend_vld,  w_pend_vld_nxt;
   logic             r_err,       w_err_nxt;
   logic             r_wrap;
   logic             r_jump_d1;
   logic [ANCHO-1:0] r_link;
   logic             r_link_vld;
   logic             w_active;
   logic             w_misaligned;

   // start_i makes RUN rules apply on the very edge that leaves IDLE/HALT
   assign w_active     = (r_state == RUN) || start_i;
   assign w_misaligned = |(jump_addr_i & c_ALIGN_MASK);

   always_comb begin
      w_state_nxt     = r_state;
      w_op_nxt        = PC_CLR;
      w_target_nxt    = r_target;
      w_pend_addr_nxt = r_pend_addr;
      w_pend_vld_nxt  = r_pend_vld;
      w_err_nxt       = r_err;

      if (r_state == HALT) begin
         w_op_nxt = PC_HOLD;
      end

      if (w_active) begin
         if (halt_i) begin
            w_state_nxt    = HALT;
            w_op_nxt       = PC_HOLD;
            w_pend_vld_nxt = 1'b0;
         end else if (jump_req_i && w_misaligned) begin
            w_err_nxt      = 1'b1;
            w_state_nxt    = HALT;
            w_op_nxt       = PC_HOLD;
            w_pend_vld_nxt = 1'b0;
         end else begin
            w_state_nxt = RUN;
            if (!stall_i && r_pend_vld) begin
               // older pending jump goes first; a same-edge request queues behind it
               w_op_nxt        = PC_JUMP;
               w_target_nxt    = r_pend_addr;
               w_pend_vld_nxt  = jump_req_i;
               w_pend_addr_nxt = jump_req_i ? jump_addr_i : r_pend_addr;
            end else if (jump_req_i && !stall_i) begin
               w_op_nxt     = PC_JUMP;
               w_target_nxt = jump_addr_i;
            end else if (jump_req_i) begin
               w_op_nxt        = PC_HOLD;
               w_pend_vld_nxt  = 1'b1;
               w_pend_addr_nxt = jump_addr_i;
            end else if (stall_i) begin
               w_op_nxt = PC_HOLD;
            end else begin
               w_op_nxt = PC_INC;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_op        <= PC_CLR;
         r_target    <= '0;
         r_pend_addr <= '0;
         r_pend_vld  <= 1'b0;
         r_err       <= 1'b0;
         r_wrap      <= 1'b0;
         r_jump_d1   <= 1'b0;
         r_link      <= '0;
         r_link_vld  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_op        <= w_op_nxt;
         r_target    <= w_target_nxt;
         r_pend_addr <= w_pend_addr_nxt;
         r_pend_vld  <= w_pend_vld_nxt;
         r_err       <= w_err_nxt;
         // link_i reflects the jump one cycle after op 11 was presented
         r_jump_d1   <= (r_op == PC_JUMP);
         r_link_vld  <= r_jump_d1;
         if (r_jump_d1) begin
            r_link <= link_i;
         end
         if ((r_op == PC_INC) && (pc_value_i == c_WRAP_PC)) begin
            r_wrap <= 1'b1;
         end
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_inc_cnt (
      .clk     (clk),
      .i_clear (reset),
      .i_inc   (w_op_nxt == PC_INC),
      .o_count (inc_count_o)
   );

   assign pc_op_o      = r_op;
   assign pc_target_o  = r_target;
   assign running_o    = (r_state == RUN);
   assign halted_o     = (r_state == HALT);
   assign err_align_o  = r_err;
   assign wrap_o       = r_wrap;
   assign link_o       = r_link;
   assign link_valid_o = r_link_vld;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Scoreboard bench for pc_sequencer against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;

   localparam int ANCHO = 4;
   localparam int CNT_W = 8;
   localparam int STEP  = 4;
   localparam logic [1:0] OP_CLR = 2'd0, OP_HOLD = 2'd1, OP_INC = 2'd2, OP_JUMP = 2'd3;

   logic             clk = 1'b0;
   logic             reset = 1'b1, start_i = 1'b0, stall_i = 1'b0, jump_req_i = 1'b0, halt_i = 1'b0;
   logic [ANCHO-1:0] jump_addr_i = '0, pc_value_i = '0, link_i = '0;
   logic [1:0]       pc_op_o;
   logic [ANCHO-1:0] pc_target_o, link_o;
   logic             running_o, halted_o, err_align_o, wrap_o, link_valid_o;
   logic [CNT_W-1:0] inc_count_o;

   pc_sequencer #(.ANCHO(ANCHO), .CNT_W(CNT_W), .STEP(STEP)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start_i),
      .stall_i      (stall_i),
      .jump_req_i   (jump_req_i),
      .jump_addr_i  (jump_addr_i),
      .halt_i       (halt_i),
      .pc_value_i   (pc_value_i),
      .link_i       (link_i),
      .pc_op_o      (pc_op_o),
      .pc_target_o  (pc_target_o),
      .running_o    (running_o),
      .halted_o     (halted_o),
      .err_align_o  (err_align_o),
      .wrap_o       (wrap_o),
      .link_o       (link_o),
      .link_valid_o (link_valid_o),
      .inc_count_o  (inc_count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      logic [3:0] tgt;
      logic       run, hlt, err, wrap, lv;
      logic [3:0] link;
      int         cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Behavioural model: running/halted flags, pending jumps as a queue,
   // and the last two presented ops to time the link capture.
   bit         m_run, m_hlt, m_err, m_wrap, m_lv;
   logic [1:0] m_op, m_prev;
   logic [3:0] m_tgt, m_link;
   int         m_cnt;
   logic [3:0] m_pend[$];

   function automatic void model_edge(bit rst, bit st, bit stl, bit jr, logic [3:0] ja,
                                      bit hl, logic [3:0] pcv, logic [3:0] lnk);
      logic [1:0] nop;
      if (rst) begin
         m_run = 0; m_hlt = 0; m_err = 0; m_wrap = 0; m_lv = 0;
         m_op = OP_CLR; m_prev = OP_CLR; m_tgt = 0; m_link = 0; m_cnt = 0;
         m_pend.delete();
         return;
      end
      m_lv = (m_prev == OP_JUMP);
      if (m_lv) m_link = lnk;
      if (m_op == OP_INC && int'(pcv) == (1 << ANCHO) - STEP) m_wrap = 1;
      nop = m_hlt ? OP_HOLD : OP_CLR;
      if (m_run || st) begin
         if (hl) begin
            m_run = 0; m_hlt = 1; nop = OP_HOLD; m_pend.delete();
         end else if (jr && (int'(ja) % STEP) != 0) begin
            m_err = 1; m_run = 0; m_hlt = 1; nop = OP_HOLD; m_pend.delete();
         end else begin
            m_run = 1; m_hlt = 0;
            if (!stl && m_pend.size() > 0) begin
               nop = OP_JUMP; m_tgt = m_pend.pop_front();
               if (jr) m_pend.push_back(ja);
            end else if (jr && !stl) begin
               nop = OP_JUMP; m_tgt = ja;
            end else if (jr) begin
               m_pend.delete(); m_pend.push_back(ja); nop = OP_HOLD;
            end else if (stl) begin
               nop = OP_HOLD;
            end else begin
               nop = OP_INC;
               if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
         end
      end
      m_prev = m_op;
      m_op   = nop;
   endfunction

   task automatic drive(bit rst, bit st, bit stl, bit jr, logic [3:0] ja,
                        bit hl, logic [3:0] pcv, logic [3:0] lnk);
      exp_t e;
      @(negedge clk);
      reset = rst; start_i = st; stall_i = stl; jump_req_i = jr;
      jump_addr_i = ja; halt_i = hl; pc_value_i = pcv; link_i = lnk;
      model_edge(rst, st, stl, jr, ja, hl, pcv, lnk);
      e.op = m_op; e.tgt = m_tgt; e.run = m_run; e.hlt = m_hlt; e.err = m_err;
      e.wrap = m_wrap; e.lv = m_lv; e.link = m_link; e.cnt = m_cnt;
      sb.push_back(e);
   endtask

   task automatic idle_cyc(logic [3:0] pcv, logic [3:0] lnk);
      drive(0, 0, 0, 0, 4'd0, 0, pcv, lnk);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // monitor: outputs are compared every cycle just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc_op",     pc_op_o,      e.op);
            chk("running",   running_o,    e.run);
            chk("halted",    halted_o,     e.hlt);
            chk("err_align", err_align_o,  e.err);
            chk("wrap",      wrap_o,       e.wrap);
            chk("link_vld",  link_valid_o, e.lv);
            chk("inc_count", inc_count_o,  e.cnt);
            if (e.op == OP_JUMP) chk("pc_target", pc_target_o, e.tgt);
            if (e.lv)            chk("link",      link_o,      e.link);
         end
      end
   end

   initial begin
      // 1: reset, start at cycle 2, free-run increments
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      chk("t1_reset_op", pc_op_o, OP_CLR);
      chk("t1_reset_target", pc_target_o, 0);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      repeat (4) idle_cyc(4'd0, 4'd0);
      settle();
      chk("t1_count5", inc_count_o, 5);
      chk("t1_op_inc", pc_op_o, OP_INC);

      // 2: jump to 8 with link capture two cycles after op 11
      drive(0, 0, 0, 1, 4'd8, 0, 4'd4, 4'd8);
      settle();
      chk("t2_jump_op", pc_op_o, OP_JUMP);
      chk("t2_jump_tgt", pc_target_o, 8);
      idle_cyc(4'd8, 4'd8);
      idle_cyc(4'd8, 4'd8);
      settle();
      chk("t2_link_vld", link_valid_o, 1);
      chk("t2_link", link_o, 8);

      // 3: two jumps queued during a 3-cycle stall; newest wins
      drive(0, 0, 1, 1, 4'd4, 0, 4'd0, 4'd0);
      drive(0, 0, 1, 1, 4'd12, 0, 4'd0, 4'd0);
      drive(0, 0, 1, 0, 4'd0, 0, 4'd0, 4'd0);
      settle();
      chk("t3_stall_op", pc_op_o, OP_HOLD);
      idle_cyc(4'd0, 4'd0);
      settle();
      chk("t3_pend_op", pc_op_o, OP_JUMP);
      chk("t3_pend_tgt", pc_target_o, 12);
      idle_cyc(4'd0, 4'd0);
      settle();
      chk("t3_single_jump", pc_op_o, OP_INC);

      // 4: misaligned jump halts with sticky error; start resumes
      drive(0, 0, 0, 1, 4'd6, 0, 4'd0, 4'd0);
      settle();
      chk("t4_err", err_align_o, 1);
      chk("t4_halted", halted_o, 1);
      chk("t4_op", pc_op_o, OP_HOLD);
      drive(0, 1, 0, 0, 4'd0, 0, 4'd0, 4'd0);
      settle();
      chk("t4_resume", running_o, 1);
      chk("t4_err_sticky", err_align_o, 1);

      // 5: increment at top of PC range sets wrap; halt beats stall
      idle_cyc(4'd12, 4'd0);
      idle_cyc(4'd0, 4'd0);
      settle();
      chk("t5_wrap", wrap_o, 1);
      drive(0, 0, 1, 0, 4'd0, 1, 4'd0, 4'd0);
      settle();
      chk("t5_halt_wins", halted_o, 1);
      chk("t5_wrap_sticky", wrap_o, 1);

      // 6: reset during a pending-jump stall clears the pending jump
      drive(0, 1, 0, 0, 4'd0, 0, 4'd0, 4'd0);
      drive(0, 0, 1, 1, 4'd8, 0, 4'd0, 4'd0);
      drive(1, 0, 1, 0, 4'd0, 0, 4'd0, 4'd0);
      settle();
      chk("t6_reset_op", pc_op_o, OP_CLR);
      drive(0, 1, 0, 0, 4'd0, 0, 4'd0, 4'd0);
      idle_cyc(4'd0, 4'd0);
      settle();
      chk("t6_no_stray_jump", pc_op_o, OP_INC);

      // random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         bit rst, st, stl, jr, hl;
         logic [3:0] ja, pcv, lnk;
         rst = ($urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 9) == 0);
         stl = ($urandom_range(0, 9) < 3);
         jr  = ($urandom_range(0, 3) == 0);
         hl  = ($urandom_range(0, 24) == 0);
         ja  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3) * STEP);
         pcv = ($urandom_range(0, 3) == 0) ? 4'd12 : 4'($urandom);
         lnk = 4'($urandom);
         drive(rst, st, stl, jr, ja, hl, pcv, lnk);
      end

      repeat (3) @(posedge clk);
      #2;
      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pc_sequencer
`default_nettype wire
